// File: rtl/flap_controller_pkg.sv
// Shared types and constants for the flap controller and its helpers.
package flap_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RISE,
    COOL,
    GLIDE,
    DEAD
  } flap_state_t;

  localparam int unsigned FLAP_TICKS_DEFAULT     = 24;
  localparam int unsigned COOLDOWN_TICKS_DEFAULT = 8;
  localparam logic [7:0]  FLAP_COUNT_MAX         = 8'd255;

  // Width of the rise and cooldown down-counters.
  localparam int unsigned CNT_W = 16;

  // Increment that sticks at FLAP_COUNT_MAX.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == FLAP_COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/flap_controller_key_sync_edge.sv
// Key synchronizer: async active-low key -> synchronized active-high level -> one-clk press pulse.
// The press pulse is registered so key-to-press latency is SYNC_STAGES+1 edges.
module key_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_now;
  logic                   synced_prev_q;
  logic                   press_q;

  assign synced_now = ~sync_q[SYNC_STAGES-1];
  assign press      = press_q;

  // Synchronizer chain (reset to "not pressed") and rising-edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= '1;
      synced_prev_q <= 1'b0;
      press_q       <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], key_n};
      synced_prev_q <= synced_now;
      press_q       <= synced_now & ~synced_prev_q;
    end
  end

endmodule

// File: rtl/flap_controller.sv
// Flap controller: turns flap presses into fixed-length rise bursts with cooldown, and runs
// the idle/playing/dead game FSM. Optional macro FLAP_RETRIGGER_EN lets a press during a rise
// reload the rise counter (and count as a flap) instead of being ignored.
module flap_controller
  import flap_controller_pkg::*;
#(
  parameter int unsigned FLAP_TICKS     = FLAP_TICKS_DEFAULT,
  parameter int unsigned COOLDOWN_TICKS = COOLDOWN_TICKS_DEFAULT,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       tick,
  input  logic       collision,
  output logic       up,
  output logic       playing,
  output logic [7:0] flap_count
);

  localparam logic [CNT_W-1:0] RISE_LOAD = CNT_W'(FLAP_TICKS);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  flap_state_t      state_q, state_d;
  logic [CNT_W-1:0] rise_q, rise_d;
  logic [CNT_W-1:0] cool_q, cool_d;
  logic [7:0]       count_q, count_d;
  logic             press;

  key_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_key_sync_edge (
    .clk  (clk),
    .reset(reset),
    .key_n(key_n),
    .press(press)
  );

  // State, counter and flap-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rise_q  <= '0;
      cool_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rise_q  <= rise_d;
      cool_q  <= cool_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; collision always beats a same-cycle press.
  always_comb begin
    state_d = state_q;
    rise_d  = rise_q;
    cool_d  = cool_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          state_d = RISE;
          rise_d  = RISE_LOAD;
          count_d = sat_inc(count_q);
        end
      end
      RISE: begin
        if (collision) begin
          state_d = DEAD;
`ifdef FLAP_RETRIGGER_EN
        end else if (press) begin
          rise_d  = RISE_LOAD;
          count_d = sat_inc(count_q);
`endif
        end else if (tick) begin
          rise_d = rise_q - CNT_ONE;
          if (rise_q == CNT_ONE) begin
            if (COOLDOWN_TICKS == 0) begin
              state_d = GLIDE;
            end else begin
              state_d = COOL;
              cool_d  = COOL_LOAD;
            end
          end
        end
      end
      COOL: begin
        if (collision) begin
          state_d = DEAD;
        end else if (tick) begin
          cool_d = cool_q - CNT_ONE;
          if (cool_q == CNT_ONE) begin
            state_d = GLIDE;
          end
        end
      end
      GLIDE: begin
        if (collision) begin
          state_d = DEAD;
        end else if (press) begin
          state_d = RISE;
          rise_d  = RISE_LOAD;
          count_d = sat_inc(count_q);
        end
      end
      DEAD: begin
        state_d = DEAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    up         = (state_q == RISE);
    playing    = (state_q == RISE) || (state_q == COOL) || (state_q == GLIDE);
    flap_count = count_q;
  end

endmodule

// File: doc/flap_controller.md
Name: flap_controller

Overview:
- Upstream stage of the bird height register; produces its `up` drive.
- Turns the raw active-low flap key into a fixed-length rise burst, followed by a cooldown, then a glide.
- Runs a small game-state FSM: idle, then playing, then dead on collision.
- Outputs `playing` and a flap counter for the score/display logic.

Parameters:
- FLAP_TICKS, 24, number of tick pulses `up` stays high per accepted flap (must be >= 1).
- COOLDOWN_TICKS, 8, tick pulses after a rise during which new presses are dropped (0 = no cooldown).
- SYNC_STAGES, 2, flip-flops in the key synchronizer (must be >= 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_n  in  1  raw asynchronous flap button, active-low
- tick  in  1  one-cycle game-rate enable; rise and cooldown counters advance only on tick
- collision  in  1  from the collision detector; level, sampled every clk
- up  out  1  drive to the bird height register; high only in RISE
- playing  out  1  high in RISE, COOL, GLIDE
- flap_count  out  8  accepted flaps since reset, saturating at 255

Behaviour:
- Reset values: state=IDLE, up=0, playing=0, flap_count=0, counters=0. The synchronizer chain is reset to "not pressed" (all 1 on key_n side).
- Key path:
  - key_n is passed through SYNC_STAGES flops, then inverted to active-high.
  - press = synced_now & ~synced_prev: a one-clk pulse on rising edge, evaluated every clk, independent of tick.
  - Key-to-press latency = SYNC_STAGES+1 clk edges. A held key produces exactly one press.
- States: IDLE, RISE, COOL, GLIDE, DEAD (2-bit+ enum). up and playing are decoded from the registered state.
- IDLE: press -> RISE. Load rise_cnt=FLAP_TICKS; flap_count+1.
- RISE:
  - On tick, rise_cnt decrements.
  - On tick with rise_cnt==1: go to COOL and load cool_cnt=COOLDOWN_TICKS, or go straight to GLIDE if COOLDOWN_TICKS==0.
  - Press in RISE is ignored (see optional feature).
- COOL:
  - Press is dropped, not queued.
  - On tick, cool_cnt decrements; on tick with cool_cnt==1 -> GLIDE.
- GLIDE: press -> RISE, reload rise_cnt=FLAP_TICKS, flap_count+1.
- DEAD:
  - up=0, playing=0.
  - Presses and ticks are ignored; only reset leaves DEAD. flap_count holds.
- Collision:
  - Collision high in RISE, COOL or GLIDE -> DEAD at the next edge, so up falls one clk after collision is sampled.
  - Collision in IDLE is ignored.
  - Collision and press in the same cycle: collision wins, and flap_count does not increment.
- Press coinciding with the terminal tick of RISE or COOL: the press is dropped, since it is evaluated against the current state.
- flap_count saturates: at 255 a further flap leaves it at 255.
- Reset mid-RISE: the next cycle is IDLE with up=0 and flap_count=0.

Optional Feature:
- Macro: FLAP_RETRIGGER_EN.
- Defined: a press in RISE reloads rise_cnt=FLAP_TICKS and increments flap_count, extending the climb. A press in the same cycle as the terminal RISE tick also reloads and stays in RISE.
- Undefined: presses in RISE are ignored, as described above.

Decomposition:
- Shared Constants package gets:
  - flap_state_t enum (IDLE, RISE, COOL, GLIDE, DEAD);
  - FLAP_TICKS_DEFAULT and COOLDOWN_TICKS_DEFAULT;
  - FLAP_COUNT_MAX=8'd255.
- Sub-module key_sync_edge: SYNC_STAGES synchronizer, active-low-to-high inversion and rising-edge pulse. Ports: clk, reset, key_n, press.
- The FSM and counters stay in flap_controller.

Test Plan:
All scenarios use FLAP_TICKS=4, COOLDOWN_TICKS=2, SYNC_STAGES=2, tick=1 every clk unless stated.
- Reset then idle: hold reset 2 clk, key_n=1 for 10 clk -> up=0, playing=0, flap_count=0, state IDLE throughout.
- Single flap:
  - Drive key_n=0 and hold it.
  - Result: up rises 4 clk after the key falls (3-edge press latency, then the state register), stays high exactly 4 clk, then COOL for 2 clk, then GLIDE.
  - flap_count=1. Holding key_n low for 20 clk gives no second flap.
- Cooldown drop: release, then press again so the press pulse lands in COOL -> no RISE and flap_count stays 1. The next press in GLIDE -> RISE and flap_count=2.
- Tick gating: tick every 3rd clk, single flap -> up high for exactly 12 clk (4 ticks).
- Collision: collision=1 during the 2nd rise tick -> up=0 and playing=0 the next clk. Then further presses over 50 clk leave state DEAD and flap_count unchanged. reset -> IDLE.
- Saturation and retrigger:
  - 260 flaps separated by more than 8 clk -> flap_count=255.
  - With FLAP_RETRIGGER_EN, a press 2 ticks into RISE -> up stays high 6 ticks total and the count increments.
